memory_stage: RTL and testbench
===============================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 64: max cycles waited for dmem_rvalid before abort.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port valid_in  input  1  inst_mem_in carries a live instruction.
REQ-005 SHALL have port inst_mem_in  input  inst_decoded_t  instruction from execute stage; dst_reg_data = effective address for load/store.
REQ-006 SHALL have port inst_mem_out  output  inst_decoded_t  instruction to writeback.
REQ-007 SHALL have port valid_out  output  1  inst_mem_out is live this cycle.
REQ-008 SHALL have port stall  output  1  upstream must hold inst_mem_in/valid_in.
REQ-009 SHALL have port dmem_req  output  1  memory request.
REQ-010 SHALL have port dmem_we  output  1  1 = store.
REQ-011 SHALL have port dmem_addr  output  ARCH_LEN  word-aligned address (bits[1:0] = 0).
REQ-012 SHALL have port dmem_wdata  output  ARCH_LEN  store data, lane-replicated.
REQ-013 SHALL have port dmem_be  output  4  byte enables.
REQ-014 SHALL have port dmem_gnt  input  1  request accepted.
REQ-015 SHALL have port dmem_rvalid  input  1  response valid (loads and stores).
REQ-016 SHALL have port dmem_rdata  input  ARCH_LEN  load word.
REQ-017 SHALL have port mem_err  output  1  one-cycle pulse: timeout or misaligned abort.

Function
REQ-018 SHALL implement FSM IDLE, REQ, WAIT, DONE.
REQ-019 IDLE: valid_in with neither is_load nor is_store -> registered pass-through, 1-cycle latency, stall=0.
REQ-020 IDLE: valid_in & (is_load|is_store) -> capture instruction, go REQ, stall=1 from that same cycle.
REQ-021 REQ: dmem_req=1, address/data/be stable until dmem_gnt; on gnt -> WAIT; gnt is sampled in REQ only.
REQ-022 WAIT: on dmem_rvalid -> DONE; counter reaching TIMEOUT_CYC -> mem_err pulse, DONE with reg_data_ready=0.
REQ-023 DONE: valid_out=1 for one cycle; stall deasserts in the cycle DONE is entered, so the next instruction is accepted in DONE; go IDLE.
REQ-024 Store be: SB 0001<<addr[1:0]; SH 0011<<addr[1:0]; SW 1111; wdata = byte/half replicated across lanes.
REQ-025 Load extract by func3: LB/LH sign-extend, LBU/LHU zero-extend, LW full word, lane from addr[1:0].
REQ-026 Load result SHALL be written to inst_mem_out.dst_reg_data with reg_data_ready=1; stores SHALL leave reg_data_ready=0.
REQ-027 dmem_rvalid outside WAIT SHALL be ignored.
REQ-028 Minimum load/store latency SHALL be 3 cycles (gnt and rvalid each in the first cycle they are possible).

Reset
REQ-029 rst SHALL immediately force state IDLE, counter 0, valid_out/stall/dmem_req/dmem_we/mem_err = 0, dmem_be = 0, inst_mem_out = 0.
REQ-030 Reset mid-transaction SHALL drop the access; later dmem_rvalid SHALL be ignored per REQ-027.

Configuration
REQ-031 With MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, SHALL skip REQ/WAIT, pulse mem_err, and deliver via DONE with reg_data_ready=0, issuing no request.
REQ-032 Without MISALIGN_TRAP_EN: misaligned accesses SHALL be issued with the address word-aligned and be truncated to lanes inside the word; mem_err only on timeout.

Structure
REQ-033 mem_state_t, load/store func3 encodings (LB..LHU, SB..SW), and TIMEOUT_CYC default SHALL live in constants_pkg; inst_decoded_t stays in instruction_pkg.
REQ-034 Lane alignment, byte enables and sign extension SHALL be one combinational sub-module, load_store_align.

Verification
REQ-035 SW addr 0x100, data 0xDEADBEEF, gnt/rvalid immediate -> dmem_be=1111, addr 0x100, valid_out after 3 cycles, reg_data_ready=0.
REQ-036 LB addr 0x103, rdata 0x80FF_FF7F -> dst_reg_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-037 SH addr 0x102, data 0x1234 -> be=1100, wdata 0x12341234.
REQ-038 ADD passing through -> 1-cycle latency, stall never asserted; back-to-back ALU ops each produce valid_out.
REQ-039 LW, rvalid never arrives -> mem_err pulse at cycle TIMEOUT_CYC in WAIT, valid_out with reg_data_ready=0; rst in WAIT -> all outputs 0 at once.
REQ-040 LW addr 0x101: with MISALIGN_TRAP_EN no dmem_req, mem_err=1; without it dmem_addr=0x100 issued.

Source files
------------

// File: rtl/constants_pkg.sv
// Memory stage states, load/store func3 encodings and shared helpers.
package constants_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2,
        MEM_DONE = 2'd3
    } mem_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam int TIMEOUT_CYC_DEFAULT = 64;

    // func3[1:0] gives access size for both loads and stores: 01 = half, 10 = word.
    function automatic logic is_misaligned(input logic [2:0] func3, input logic [1:0] addr_lo);
        logic mis;
        case (func3[1:0])
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/instruction_pkg.sv
// Decoded instruction record passed between pipeline stages.
package instruction_pkg;

    localparam int ARCH_LEN = 32;

    typedef struct packed {
        logic [ARCH_LEN-1:0] pc;
        logic [4:0]          dst_reg;
        logic [2:0]          func3;
        logic                is_load;
        logic                is_store;
        logic [ARCH_LEN-1:0] src2_data;      // store data for SB/SH/SW
        logic [ARCH_LEN-1:0] dst_reg_data;   // ALU result, or effective address for load/store
        logic                reg_data_ready;
    } inst_decoded_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane steering: store byte enables / replicated data, load lane extract and extension.
module load_store_align
    import instruction_pkg::*;
    import constants_pkg::*;
(
    input  logic [2:0]          func3,
    input  logic [1:0]          addr_lo,
    input  logic [ARCH_LEN-1:0] store_data,
    input  logic [ARCH_LEN-1:0] rdata,
    output logic [3:0]          be,
    output logic [ARCH_LEN-1:0] wdata,
    output logic [ARCH_LEN-1:0] load_data
);

    logic [ARCH_LEN-1:0] lane_s;

    // Shifting left by the byte offset drops any lanes that would spill past the word.
    always_comb begin
        be    = 4'b0000;
        wdata = store_data;
        case (func3)
            F3_SB: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            F3_SH: begin
                be    = 4'b0011 << addr_lo;
                wdata = {2{store_data[15:0]}};
            end
            F3_SW: begin
                be    = 4'b1111;
                wdata = store_data;
            end
            default: begin
                be    = 4'b0000;
                wdata = store_data;
            end
        endcase
    end

    assign lane_s = rdata >> {addr_lo, 3'b000};

    // Load extraction from the addressed lane.
    always_comb begin
        load_data = rdata;
        case (func3)
            F3_LB:   load_data = {{24{lane_s[7]}}, lane_s[7:0]};
            F3_LH:   load_data = {{16{lane_s[15]}}, lane_s[15:0]};
            F3_LW:   load_data = rdata;
            F3_LBU:  load_data = {24'h000000, lane_s[7:0]};
            F3_LHU:  load_data = {16'h0000, lane_s[15:0]};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: ALU ops pass through in one cycle, loads/stores run a REQ/WAIT handshake.
// Optional build macro MISALIGN_TRAP_EN aborts misaligned halfword/word accesses without a request.
module memory_stage
    import instruction_pkg::*;
    import constants_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    input  inst_decoded_t       inst_mem_in,
    output inst_decoded_t       inst_mem_out,
    output logic                valid_out,
    output logic                stall,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [ARCH_LEN-1:0] dmem_addr,
    output logic [ARCH_LEN-1:0] dmem_wdata,
    output logic [3:0]          dmem_be,
    input  logic                dmem_gnt,
    input  logic                dmem_rvalid,
    input  logic [ARCH_LEN-1:0] dmem_rdata,
    output logic                mem_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    mem_state_t          state_r;
    inst_decoded_t       inst_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                stall_r;

    logic                accept_s;
    logic                is_mem_s;
    logic                misalign_trap_s;
    logic [2:0]          sel_func3_s;
    logic [1:0]          sel_addr_lo_s;
    logic [ARCH_LEN-1:0] sel_store_data_s;
    logic [3:0]          be_s;
    logic [ARCH_LEN-1:0] wdata_s;
    logic [ARCH_LEN-1:0] load_data_s;

    assign accept_s = (state_r == MEM_IDLE) || (state_r == MEM_DONE);
    assign is_mem_s = inst_mem_in.is_load | inst_mem_in.is_store;
    // Holding starts combinationally in the capture cycle, then continues from stall_r.
    assign stall    = stall_r | (accept_s & valid_in & is_mem_s);

`ifdef MISALIGN_TRAP_EN
    assign misalign_trap_s = is_misaligned(inst_mem_in.func3, inst_mem_in.dst_reg_data[1:0]);
`else
    assign misalign_trap_s = 1'b0;
`endif

    // Aligner sees the incoming instruction while accepting (store lanes), the captured one otherwise (load lanes).
    always_comb begin
        if (accept_s) begin
            sel_func3_s      = inst_mem_in.func3;
            sel_addr_lo_s    = inst_mem_in.dst_reg_data[1:0];
            sel_store_data_s = inst_mem_in.src2_data;
        end else begin
            sel_func3_s      = inst_r.func3;
            sel_addr_lo_s    = inst_r.dst_reg_data[1:0];
            sel_store_data_s = inst_r.src2_data;
        end
    end

    load_store_align u_align (
        .func3      (sel_func3_s),
        .addr_lo    (sel_addr_lo_s),
        .store_data (sel_store_data_s),
        .rdata      (dmem_rdata),
        .be         (be_s),
        .wdata      (wdata_s),
        .load_data  (load_data_s)
    );

    // Stage FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= MEM_IDLE;
            inst_r       <= '0;
            cnt_r        <= '0;
            stall_r      <= 1'b0;
            inst_mem_out <= '0;
            valid_out    <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            dmem_be      <= 4'b0000;
            mem_err      <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            mem_err   <= 1'b0;
            case (state_r)
                MEM_IDLE, MEM_DONE: begin
                    state_r <= MEM_IDLE;
                    if (valid_in && is_mem_s) begin
                        inst_r <= inst_mem_in;
                        if (misalign_trap_s) begin
                            state_r                     <= MEM_DONE;
                            mem_err                     <= 1'b1;
                            valid_out                   <= 1'b1;
                            inst_mem_out                <= inst_mem_in;
                            inst_mem_out.reg_data_ready <= 1'b0;
                        end else begin
                            state_r    <= MEM_REQ;
                            stall_r    <= 1'b1;
                            dmem_req   <= 1'b1;
                            dmem_we    <= inst_mem_in.is_store;
                            dmem_addr  <= {inst_mem_in.dst_reg_data[ARCH_LEN-1:2], 2'b00};
                            dmem_wdata <= wdata_s;
                            dmem_be    <= inst_mem_in.is_store ? be_s : 4'b1111;
                        end
                    end else if (valid_in) begin
                        inst_mem_out <= inst_mem_in;
                        valid_out    <= 1'b1;
                    end else begin
                        state_r <= MEM_IDLE;
                    end
                end
                MEM_REQ: begin
                    if (dmem_gnt) begin
                        state_r  <= MEM_WAIT;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        dmem_be  <= 4'b0000;
                        cnt_r    <= '0;
                    end else begin
                        state_r <= MEM_REQ;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_rvalid) begin
                        state_r      <= MEM_DONE;
                        stall_r      <= 1'b0;
                        valid_out    <= 1'b1;
                        inst_mem_out <= inst_r;
                        if (inst_r.is_load) begin
                            inst_mem_out.dst_reg_data   <= load_data_s;
                            inst_mem_out.reg_data_ready <= 1'b1;
                        end else begin
                            inst_mem_out.reg_data_ready <= 1'b0;
                        end
                    end else if (cnt_r == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state_r                     <= MEM_DONE;
                        stall_r                     <= 1'b0;
                        valid_out                   <= 1'b1;
                        mem_err                     <= 1'b1;
                        inst_mem_out                <= inst_r;
                        inst_mem_out.reg_data_ready <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= MEM_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage; honours MISALIGN_TRAP_EN like the RTL.
module tb_memory_stage;
    import instruction_pkg::*;
    import constants_pkg::*;

    localparam int TO = 64;

    logic                clk;
    logic                rst;
    logic                valid_in;
    inst_decoded_t       inst_mem_in;
    inst_decoded_t       inst_mem_out;
    logic                valid_out;
    logic                stall;
    logic                dmem_req;
    logic                dmem_we;
    logic [ARCH_LEN-1:0] dmem_addr;
    logic [ARCH_LEN-1:0] dmem_wdata;
    logic [3:0]          dmem_be;
    logic                dmem_gnt;
    logic                dmem_rvalid;
    logic [ARCH_LEN-1:0] dmem_rdata;
    logic                mem_err;

    int pass_cnt = 0;
    int total_cnt = 0;

    int                  lat;
    logic                saw_req, saw_err, stall_at_issue, req_we;
    logic [ARCH_LEN-1:0] req_addr, req_wdata;
    logic [3:0]          req_be;
    inst_decoded_t       out_inst;

    memory_stage #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .inst_mem_in(inst_mem_in),
        .inst_mem_out(inst_mem_out), .valid_out(valid_out), .stall(stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic inst_decoded_t mk(input logic ld, input logic st, input logic [2:0] f3,
                                         input logic [31:0] addr, input logic [31:0] src2,
                                         input logic rdy);
        inst_decoded_t i;
        i = '0;
        i.pc = 32'h0000_1000;
        i.dst_reg = 5'd7;
        i.func3 = f3;
        i.is_load = ld;
        i.is_store = st;
        i.src2_data = src2;
        i.dst_reg_data = addr;
        i.reg_data_ready = rdy;
        return i;
    endfunction

    // Present one instruction for a cycle, then follow it until valid_out (bounded).
    task automatic issue(input inst_decoded_t i);
        valid_in = 1'b1;
        inst_mem_in = i;
        #1 stall_at_issue = stall;
        saw_req = 1'b0; saw_err = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; req_be = 4'b0000;
        @(posedge clk); #1;
        valid_in = 1'b0;
        inst_mem_in = '0;
        lat = 1;
        while (!valid_out && lat < 200) begin
            if (dmem_req && !saw_req) begin
                saw_req = 1'b1; req_addr = dmem_addr; req_wdata = dmem_wdata;
                req_be = dmem_be; req_we = dmem_we;
            end
            saw_err = saw_err | mem_err;
            @(posedge clk); #1;
            lat++;
        end
        saw_err = saw_err | mem_err;
        out_inst = inst_mem_out;
    endtask

    task automatic test_reset;
        rst = 1'b1; valid_in = 1'b0; inst_mem_in = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        #2;
        total_cnt++;
        if ({valid_out, stall, dmem_req, dmem_we, mem_err, dmem_be} !== 9'b0)
            $display("FAIL reset_ctrl: got %b want 0", {valid_out, stall, dmem_req, dmem_we, mem_err, dmem_be});
        else pass_cnt++;
        total_cnt++;
        if (inst_mem_out !== '0) $display("FAIL reset_inst: got %h want 0", inst_mem_out);
        else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
        dmem_rvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            total_cnt++;
            if ({valid_out, mem_err, dmem_req} !== 3'b000)
                $display("FAIL stray_rvalid: got %b want 000", {valid_out, mem_err, dmem_req});
            else pass_cnt++;
        end
        dmem_rvalid = 1'b0;
    endtask

    task automatic test_passthrough;
        inst_decoded_t i;
        i = mk(1'b0, 1'b0, 3'b000, 32'h0000_0055, 32'h0, 1'b1);
        issue(i);
        total_cnt++;
        if (stall_at_issue !== 1'b0) $display("FAIL add_stall: got %b want 0", stall_at_issue);
        else pass_cnt++;
        total_cnt++;
        if (lat !== 1) $display("FAIL add_latency: got %0d want 1", lat);
        else pass_cnt++;
        total_cnt++;
        if (out_inst !== i) $display("FAIL add_out: got %h want %h", out_inst, i);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        inst_decoded_t i [3];
        for (int k = 0; k < 3; k++)
            i[k] = mk(1'b0, 1'b0, 3'b000, 32'h0000_0A00 + k, 32'h0, 1'b1);
        valid_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            inst_mem_in = i[k];
            #1;
            total_cnt++;
            if (stall !== 1'b0) $display("FAIL b2b_stall%0d: got %b want 0", k, stall);
            else pass_cnt++;
            @(posedge clk); #1;
            total_cnt++;
            if (valid_out !== 1'b1 || inst_mem_out !== i[k])
                $display("FAIL b2b_out%0d: got v=%b %h want v=1 %h", k, valid_out, inst_mem_out, i[k]);
            else pass_cnt++;
        end
        valid_in = 1'b0;
        inst_mem_in = '0;
        @(posedge clk); #1;
        total_cnt++;
        if (valid_out !== 1'b0) $display("FAIL b2b_idle: got %b want 0", valid_out);
        else pass_cnt++;
    endtask

    task automatic test_store;
        inst_decoded_t i, e;
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1;
        i = mk(1'b0, 1'b1, F3_SW, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1);
        issue(i);
        e = i; e.reg_data_ready = 1'b0;
        total_cnt++;
        if (stall_at_issue !== 1'b1) $display("FAIL sw_stall: got %b want 1", stall_at_issue);
        else pass_cnt++;
        total_cnt++;
        if ({saw_req, req_we, req_be, req_addr, req_wdata} !== {1'b1, 1'b1, 4'b1111, 32'h0000_0100, 32'hDEAD_BEEF})
            $display("FAIL sw_req: got req=%b we=%b be=%b a=%h d=%h want 1 1 1111 00000100 deadbeef",
                     saw_req, req_we, req_be, req_addr, req_wdata);
        else pass_cnt++;
        total_cnt++;
        if (lat !== 3 || saw_err !== 1'b0) $display("FAIL sw_latency: got %0d err=%b want 3 err=0", lat, saw_err);
        else pass_cnt++;
        total_cnt++;
        if (out_inst !== e) $display("FAIL sw_out: got %h want %h", out_inst, e);
        else pass_cnt++;
        total_cnt++;
        if (stall !== 1'b0) $display("FAIL sw_done_stall: got %b want 0", stall);
        else pass_cnt++;

        issue(mk(1'b0, 1'b1, F3_SH, 32'h0000_0102, 32'hABCD_1234, 1'b0));
        total_cnt++;
        if ({req_be, req_addr, req_wdata} !== {4'b1100, 32'h0000_0100, 32'h1234_1234})
            $display("FAIL sh_req: got be=%b a=%h d=%h want 1100 00000100 12341234", req_be, req_addr, req_wdata);
        else pass_cnt++;

        issue(mk(1'b0, 1'b1, F3_SB, 32'h0000_0101, 32'h0000_00AB, 1'b0));
        total_cnt++;
        if ({req_be, req_wdata} !== {4'b0010, 32'hABAB_ABAB})
            $display("FAIL sb_req: got be=%b d=%h want 0010 abababab", req_be, req_wdata);
        else pass_cnt++;
    endtask

    task automatic test_load;
        inst_decoded_t i, e;
        logic [2:0]  f3  [5] = '{F3_LB, F3_LBU, F3_LH, F3_LHU, F3_LW};
        logic [31:0] ad  [5] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h100};
        logic [31:0] exp [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_FF7F, 32'h80FF_FF7F};
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1;
        dmem_rdata = 32'h80FF_FF7F;
        for (int k = 0; k < 5; k++) begin
            i = mk(1'b1, 1'b0, f3[k], ad[k], 32'h0, 1'b0);
            issue(i);
            e = i; e.dst_reg_data = exp[k]; e.reg_data_ready = 1'b1;
            total_cnt++;
            if (out_inst !== e || lat !== 3 || req_we !== 1'b0 || req_addr !== 32'h0000_0100)
                $display("FAIL load%0d: got %h lat=%0d we=%b a=%h want %h lat=3 we=0 a=00000100",
                         k, out_inst, lat, req_we, req_addr, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_misalign;
        inst_decoded_t i;
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        i = mk(1'b1, 1'b0, F3_LW, 32'h0000_0101, 32'h0, 1'b0);
        issue(i);
`ifdef MISALIGN_TRAP_EN
        total_cnt++;
        if ({saw_req, saw_err, out_inst.reg_data_ready} !== 3'b010 || lat !== 1)
            $display("FAIL lw_trap: got req=%b err=%b rdy=%b lat=%0d want 0 1 0 lat=1",
                     saw_req, saw_err, out_inst.reg_data_ready, lat);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (mem_err !== 1'b0) $display("FAIL lw_trap_pulse: got %b want 0", mem_err);
        else pass_cnt++;
`else
        total_cnt++;
        if (saw_req !== 1'b1 || req_addr !== 32'h0000_0100 || saw_err !== 1'b0 || lat !== 3)
            $display("FAIL lw_mis_req: got req=%b a=%h err=%b lat=%0d want 1 00000100 0 3",
                     saw_req, req_addr, saw_err, lat);
        else pass_cnt++;
        total_cnt++;
        if ({out_inst.reg_data_ready, out_inst.dst_reg_data} !== {1'b1, 32'hCAFE_F00D})
            $display("FAIL lw_mis_data: got %b %h want 1 cafef00d", out_inst.reg_data_ready, out_inst.dst_reg_data);
        else pass_cnt++;
        issue(mk(1'b0, 1'b1, F3_SH, 32'h0000_0103, 32'h0000_5678, 1'b0));
        total_cnt++;
        if ({req_be, req_wdata} !== {4'b1000, 32'h5678_5678})
            $display("FAIL sh_mis: got be=%b d=%h want 1000 56785678", req_be, req_wdata);
        else pass_cnt++;
        dmem_rdata = 32'h80FF_FF7F;
        issue(mk(1'b1, 1'b0, F3_LH, 32'h0000_0103, 32'h0, 1'b0));
        total_cnt++;
        if (out_inst.dst_reg_data !== 32'h0000_0080)
            $display("FAIL lh_mis: got %h want 00000080", out_inst.dst_reg_data);
        else pass_cnt++;
`endif
    endtask

    task automatic test_timeout;
        dmem_gnt = 1'b1; dmem_rvalid = 1'b0;
        issue(mk(1'b1, 1'b0, F3_LW, 32'h0000_0200, 32'h0, 1'b0));
        total_cnt++;
        if (lat !== TO + 2 || saw_req !== 1'b1) $display("FAIL timeout_latency: got %0d req=%b want %0d req=1", lat, saw_req, TO + 2);
        else pass_cnt++;
        total_cnt++;
        if (mem_err !== 1'b1 || out_inst.reg_data_ready !== 1'b0)
            $display("FAIL timeout_err: got err=%b rdy=%b want 1 0", mem_err, out_inst.reg_data_ready);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if ({mem_err, valid_out} !== 2'b00) $display("FAIL timeout_pulse: got %b want 00", {mem_err, valid_out});
        else pass_cnt++;
    endtask

    task automatic test_reset_in_wait;
        dmem_gnt = 1'b1; dmem_rvalid = 1'b0;
        valid_in = 1'b1;
        inst_mem_in = mk(1'b1, 1'b0, F3_LW, 32'h0000_0300, 32'h0, 1'b0);
        @(posedge clk); #1;
        valid_in = 1'b0; inst_mem_in = '0;
        repeat (4) begin @(posedge clk); #1; end
        total_cnt++;
        if (stall !== 1'b1) $display("FAIL wait_stall: got %b want 1", stall);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if ({valid_out, stall, dmem_req, dmem_we, mem_err, dmem_be} !== 9'b0 || inst_mem_out !== '0)
            $display("FAIL rst_wait: got %b %h want 0 0", {valid_out, stall, dmem_req, dmem_we, mem_err, dmem_be}, inst_mem_out);
        else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
        dmem_rvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            total_cnt++;
            if ({valid_out, stall, dmem_req} !== 3'b000)
                $display("FAIL rst_drop%0d: got %b want 000", k, {valid_out, stall, dmem_req});
            else pass_cnt++;
        end
        dmem_rvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_back_to_back();
        test_store();
        test_load();
        test_misalign();
        test_timeout();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
